// File: rtl/esc_deserializer_if.sv
// -----------------------------------------------------------------------------
// esc_deserializer_if
//   Bundles the serial input and the PPI RX escape outputs of
//   esc_deserializer. The clock (RxClkEsc) and reset (RstN) are not part of
//   this bundle; they are plain ports on the deserializer.
//
//   Signals:
//     SerBit        serial bit, MSB of each byte first
//     EscDesEn      high for the whole escape sequence
//     RxDataEsc     last completed LPDT payload byte
//     RxValidEsc    one-cycle strobe, RxDataEsc new in this cycle
//     RxLpdtEsc     high while in LPDT mode
//     RxUlpsEsc     high while in ULPS
//     RxTriggerEsc  one-cycle pulse on trigger-reset command
//     ErrEsc        one-cycle pulse on unrecognised command
//     ErrSyncEsc    one-cycle pulse when EscDesEn falls mid-byte
//     RxByteCnt     LPDT payload byte count (only with ESC_BYTE_CNT_EN)
//
//   Handshake: RxValidEsc is a strobe with no ready/backpressure. The byte on
//   RxDataEsc is valid in exactly the cycle RxValidEsc is high and the
//   consumer must take it then; RxDataEsc holds between strobes.
//
//   Modports: slave = the deserializer, master = the bit-recovery side that
//   drives SerBit/EscDesEn and consumes the outputs.
//   Optional macro: ESC_BYTE_CNT_EN adds RxByteCnt.
// -----------------------------------------------------------------------------
interface esc_deserializer_if;
  logic        SerBit;
  logic        EscDesEn;
  logic [7:0]  RxDataEsc;
  logic        RxValidEsc;
  logic        RxLpdtEsc;
  logic        RxUlpsEsc;
  logic        RxTriggerEsc;
  logic        ErrEsc;
  logic        ErrSyncEsc;
`ifdef ESC_BYTE_CNT_EN
  logic [15:0] RxByteCnt;
`endif

  modport slave (
    input  SerBit,
    input  EscDesEn,
    output RxDataEsc,
    output RxValidEsc,
    output RxLpdtEsc,
    output RxUlpsEsc,
    output RxTriggerEsc,
    output ErrEsc,
    output ErrSyncEsc
`ifdef ESC_BYTE_CNT_EN
    , output RxByteCnt
`endif
  );

  modport master (
    output SerBit,
    output EscDesEn,
    input  RxDataEsc,
    input  RxValidEsc,
    input  RxLpdtEsc,
    input  RxUlpsEsc,
    input  RxTriggerEsc,
    input  ErrEsc,
    input  ErrSyncEsc
`ifdef ESC_BYTE_CNT_EN
    , input RxByteCnt
`endif
  );
endinterface

// File: rtl/esc_deserializer.sv
// -----------------------------------------------------------------------------
// esc_deserializer
//   Escape-mode receive deserializer. Shifts in one serial bit per RxClkEsc
//   rising edge (MSB first) while EscDesEn is high. The first byte of each
//   escape sequence is an entry command (LPDT / ULPS / trigger-reset); in
//   LPDT each following byte is presented on RxDataEsc with a one-cycle
//   RxValidEsc strobe.
//
//   Ports:
//     RxClkEsc     in   escape clock, one bit sampled per rising edge
//     RstN         in   asynchronous reset, active low
//     bus          if   esc_deserializer_if.slave (serial in, PPI outputs)
//     o_dbg_state  out  current FSM state (IDLE=0, CMD, LPDT, ULPS, HOLD)
//
//   Optional macro: ESC_BYTE_CNT_EN adds the 16-bit saturating LPDT payload
//   byte counter RxByteCnt.
// -----------------------------------------------------------------------------
module esc_deserializer #(
  parameter logic [7:0] LPDT_CMD = 8'hE1,
  parameter logic [7:0] ULPS_CMD = 8'h1E,
  parameter logic [7:0] TRIG_CMD = 8'h62
) (
  input  logic                RxClkEsc,
  input  logic                RstN,
  esc_deserializer_if.slave   bus,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_LPDT = 3'd2,
    ST_ULPS = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  state_t     r_state;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_shift;     // only the 7 oldest bits are needed; SerBit completes the byte
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_lpdt;
  logic       r_ulps;
  logic       r_trig;
  logic       r_err;
  logic       r_errsync;

  state_t     w_state_nxt;
  logic [2:0] w_bit_cnt_nxt;
  logic [6:0] w_shift_nxt;
  logic       w_valid_nxt;
  logic       w_trig_nxt;
  logic       w_err_nxt;
  logic       w_errsync_nxt;
  logic       w_load;
  logic       w_entry;
  logic [7:0] w_byte;
  logic       w_byte_done;

  assign w_byte      = {r_shift, bus.SerBit};
  assign w_byte_done = (r_bit_cnt == 3'd7);

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_valid_nxt   = 1'b0;
    w_trig_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_errsync_nxt = 1'b0;
    w_load        = 1'b0;
    w_entry       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Entry edge already samples bit 7 of the command byte
        if (bus.EscDesEn) begin
          w_state_nxt   = ST_CMD;
          w_entry       = 1'b1;
          w_bit_cnt_nxt = 3'd1;
          w_shift_nxt   = w_byte[6:0];
        end
      end

      ST_CMD: begin
        if (!bus.EscDesEn) begin
          w_state_nxt   = ST_IDLE;
          w_bit_cnt_nxt = 3'd0;
          w_shift_nxt   = 7'd0;
          w_errsync_nxt = (r_bit_cnt != 3'd0);
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;   // wraps 7 -> 0 on byte completion
          w_shift_nxt   = w_byte[6:0];
          if (w_byte_done) begin
            if (w_byte == LPDT_CMD) begin
              w_state_nxt = ST_LPDT;
            end else if (w_byte == ULPS_CMD) begin
              w_state_nxt = ST_ULPS;
            end else if (w_byte == TRIG_CMD) begin
              w_state_nxt = ST_HOLD;
              w_trig_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_HOLD;
              w_err_nxt   = 1'b1;
            end
          end
        end
      end

      ST_LPDT: begin
        if (!bus.EscDesEn) begin
          // A partial byte is dropped; only a mid-byte exit is a sync error
          w_state_nxt   = ST_IDLE;
          w_bit_cnt_nxt = 3'd0;
          w_shift_nxt   = 7'd0;
          w_errsync_nxt = (r_bit_cnt != 3'd0);
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          w_shift_nxt   = w_byte[6:0];
          if (w_byte_done) begin
            w_load      = 1'b1;
            w_valid_nxt = 1'b1;
          end
        end
      end

      ST_ULPS, ST_HOLD: begin
        // Bits are ignored; counter and shift stay frozen until exit
        if (!bus.EscDesEn) begin
          w_state_nxt   = ST_IDLE;
          w_bit_cnt_nxt = 3'd0;
          w_shift_nxt   = 7'd0;
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_bit_cnt_nxt = 3'd0;
        w_shift_nxt   = 7'd0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge RxClkEsc or negedge RstN) begin
    if (!RstN) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 7'd0;
      r_data    <= 8'd0;
      r_valid   <= 1'b0;
      r_lpdt    <= 1'b0;
      r_ulps    <= 1'b0;
      r_trig    <= 1'b0;
      r_err     <= 1'b0;
      r_errsync <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_valid   <= w_valid_nxt;
      r_lpdt    <= (w_state_nxt == ST_LPDT);
      r_ulps    <= (w_state_nxt == ST_ULPS);
      r_trig    <= w_trig_nxt;
      r_err     <= w_err_nxt;
      r_errsync <= w_errsync_nxt;
      if (w_load) begin
        r_data <= w_byte;
      end
    end
  end

`ifdef ESC_BYTE_CNT_EN
  logic [15:0] r_byte_cnt;

  // Cleared on entry, counts with each strobe, saturates, holds after exit
  always_ff @(posedge RxClkEsc or negedge RstN) begin
    if (!RstN) begin
      r_byte_cnt <= 16'd0;
    end else if (w_entry) begin
      r_byte_cnt <= 16'd0;
    end else if (w_valid_nxt && (r_byte_cnt != 16'hFFFF)) begin
      r_byte_cnt <= r_byte_cnt + 16'd1;
    end
  end

  assign bus.RxByteCnt = r_byte_cnt;
`endif

  assign bus.RxDataEsc    = r_data;
  assign bus.RxValidEsc   = r_valid;
  assign bus.RxLpdtEsc    = r_lpdt;
  assign bus.RxUlpsEsc    = r_ulps;
  assign bus.RxTriggerEsc = r_trig;
  assign bus.ErrEsc       = r_err;
  assign bus.ErrSyncEsc   = r_errsync;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_esc_deserializer.sv
// -----------------------------------------------------------------------------
// tb_esc_deserializer
//   Drives escape sequences bit by bit and compares every cycle's outputs
//   against a sequence-level reference model derived from the command byte,
//   the number of enabled edges and the idle tail that follows.
//   Output vector layout (MSB..LSB):
//     {RxLpdtEsc, RxUlpsEsc, RxTriggerEsc, ErrEsc, ErrSyncEsc, RxValidEsc,
//      RxDataEsc[7:0] [, RxByteCnt[15:0] with ESC_BYTE_CNT_EN]}
// -----------------------------------------------------------------------------
module tb_esc_deserializer;

  localparam logic [7:0] LPDT_CMD = 8'hE1;
  localparam logic [7:0] ULPS_CMD = 8'h1E;
  localparam logic [7:0] TRIG_CMD = 8'h62;
`ifdef ESC_BYTE_CNT_EN
  localparam int W = 30;
`else
  localparam int W = 14;
`endif

  // ---------------- clock / reset ----------------
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  esc_deserializer_if bus ();

  esc_deserializer dut (
    .RxClkEsc    (clk),
    .RstN        (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int           checks   = 0;
  int           failures = 0;
  logic [7:0]   tx_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [7:0]   last_data;
`ifdef ESC_BYTE_CNT_EN
  logic [15:0]  last_cnt;
`endif

  function automatic logic [13:0] pack(input logic lp, input logic ul,
                                       input logic tr, input logic er,
                                       input logic es, input logic va,
                                       input logic [7:0] d);
    return {lp, ul, tr, er, es, va, d};
  endfunction

  function automatic logic [W-1:0] sample_outputs();
`ifdef ESC_BYTE_CNT_EN
    return {bus.RxLpdtEsc, bus.RxUlpsEsc, bus.RxTriggerEsc, bus.ErrEsc,
            bus.ErrSyncEsc, bus.RxValidEsc, bus.RxDataEsc, bus.RxByteCnt};
`else
    return {bus.RxLpdtEsc, bus.RxUlpsEsc, bus.RxTriggerEsc, bus.ErrEsc,
            bus.ErrSyncEsc, bus.RxValidEsc, bus.RxDataEsc};
`endif
  endfunction

  // Reference model: n enabled edges carrying tx_q MSB-first, then `tail`
  // edges with EscDesEn low. Edge t (1-based) is the t-th edge of the burst.
  task automatic model_seq(input int n, input int tail);
    logic [7:0] cmd;
    bit has_cmd, is_l, is_u, is_t, is_b;
    bit lp, ul, tr, er, es, va;
    exp_q.delete();
    has_cmd = (n >= 8);
    cmd     = tx_q[0];
    is_l    = has_cmd && (cmd == LPDT_CMD);
    is_u    = has_cmd && (cmd == ULPS_CMD);
    is_t    = has_cmd && (cmd == TRIG_CMD);
    is_b    = has_cmd && !is_l && !is_u && !is_t;
    for (int t = 1; t <= n + tail; t++) begin
      lp = is_l && (t >= 8) && (t <= n);
      ul = is_u && (t >= 8) && (t <= n);
      tr = is_t && (t == 8);
      er = is_b && (t == 8);
      va = is_l && (t <= n) && (t >= 16) && ((t % 8) == 0);
      if (va) last_data = tx_q[t / 8 - 1];
      es = (t == n + 1) && ((n % 8) != 0) && (!has_cmd || is_l);
`ifdef ESC_BYTE_CNT_EN
      if (t == 1) last_cnt = 16'd0;
      if (va && (last_cnt != 16'hFFFF)) last_cnt = last_cnt + 16'd1;
      exp_q.push_back({pack(lp, ul, tr, er, es, va, last_data), last_cnt});
`else
      exp_q.push_back(pack(lp, ul, tr, er, es, va, last_data));
`endif
    end
  endtask

  // ---------------- driver ----------------
  // Called between edges; returns #1 after the last edge it drove.
  task automatic play_seq(input int n, input int tail);
    logic [7:0] b;
    obs_q.delete();
    for (int t = 0; t < n + tail; t++) begin
      if (t < n) begin
        bus.EscDesEn = 1'b1;
        if (t / 8 < tx_q.size()) begin
          b          = tx_q[t / 8];
          bus.SerBit = b[7 - (t % 8)];
        end else begin
          bus.SerBit = 1'($urandom_range(0, 1));
        end
      end else begin
        bus.EscDesEn = 1'b0;
        bus.SerBit   = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      obs_q.push_back(sample_outputs());
    end
    bus.EscDesEn = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n        = 1'b0;
    bus.EscDesEn = 1'b1;   // must be ignored while held in reset
    bus.SerBit   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sample_outputs() !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", sample_outputs(), {W{1'b0}});
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
    bus.EscDesEn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sample_outputs() !== '0) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", sample_outputs(), {W{1'b0}});
    end
    last_data = 8'h00;
`ifdef ESC_BYTE_CNT_EN
    last_cnt = 16'd0;
`endif
  endtask

  task automatic test_lpdt();
    int k, n;
    tx_q = '{LPDT_CMD, 8'hA5, 8'h3C};
    model_seq(24, 2);
    play_seq(24, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL lpdt_fixed cycle=%0d got=%h exp=%h", i + 1, obs_q[i], exp_q[i]);
      end
    end
    for (int r = 0; r < 3; r++) begin
      k = $urandom_range(1, 4);
      tx_q = '{LPDT_CMD};
      for (int j = 0; j < k; j++) tx_q.push_back(8'($urandom_range(0, 255)));
      n = 8 * (k + 1);
      model_seq(n, 2);
      play_seq(n, 2);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL lpdt_rand run=%0d cycle=%0d got=%h exp=%h", r, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_ulps();
    tx_q = '{ULPS_CMD};
    model_seq(28, 2);
    play_seq(28, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL ulps cycle=%0d got=%h exp=%h", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_trigger();
    int n;
    tx_q = '{TRIG_CMD};
    n = 8 + $urandom_range(0, 12);
    model_seq(n, 2);
    play_seq(n, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL trigger cycle=%0d got=%h exp=%h", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] c;
    for (int r = 0; r < 3; r++) begin
      if (r == 0) begin
        c = 8'h00;
      end else begin
        do c = 8'($urandom_range(0, 255));
        while (c == LPDT_CMD || c == ULPS_CMD || c == TRIG_CMD);
      end
      tx_q = '{c};
      model_seq(8 + 8 * r, 2);
      play_seq(8 + 8 * r, 2);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL bad_cmd cmd=%h cycle=%0d got=%h exp=%h", c, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_sync_error();
    int n;
    for (int r = 0; r < 4; r++) begin
      tx_q = '{LPDT_CMD, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
      case (r)
        0:       n = 8 + 5;                          // partial first payload byte
        1:       n = 16 + $urandom_range(1, 7);      // partial after a full byte
        default: n = $urandom_range(1, 7);           // exit inside the command byte
      endcase
      model_seq(n, 2);
      play_seq(n, 2);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL sync_err run=%0d n=%0d cycle=%0d got=%h exp=%h", r, n, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int kind, k, n;
    for (int r = 0; r < 8; r++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          k = $urandom_range(1, 3);
          tx_q = '{LPDT_CMD};
          for (int j = 0; j < k + 1; j++) tx_q.push_back(8'($urandom_range(0, 255)));
          n = 8 * (k + 1) + $urandom_range(0, 7);
        end
        1: begin tx_q = '{ULPS_CMD}; n = 8 + $urandom_range(0, 10); end
        2: begin tx_q = '{TRIG_CMD}; n = 8 + $urandom_range(0, 10); end
        default: begin tx_q = '{8'h5A}; n = 8 + $urandom_range(0, 10); end
      endcase
      model_seq(n, 1);   // single idle edge, then straight back in
      play_seq(n, 1);
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL b2b run=%0d kind=%0d cycle=%0d got=%h exp=%h", r, kind, i + 1, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_lpdt();
    tx_q = '{LPDT_CMD, 8'($urandom_range(0, 255))};
    model_seq(11, 0);
    play_seq(11, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL mid_rst_pre cycle=%0d got=%h exp=%h", i + 1, obs_q[i], exp_q[i]);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sample_outputs() !== '0) begin
      failures++;
      $display("FAIL mid_rst_async got=%h exp=%h", sample_outputs(), {W{1'b0}});
    end
    @(negedge clk);
    rst_n     = 1'b1;
    last_data = 8'h00;
`ifdef ESC_BYTE_CNT_EN
    last_cnt = 16'd0;
`endif
    tx_q = '{LPDT_CMD, 8'h7F};
    model_seq(16, 2);
    play_seq(16, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL mid_rst_post cycle=%0d got=%h exp=%h", i + 1, obs_q[i], exp_q[i]);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    bus.SerBit   = 1'b0;
    bus.EscDesEn = 1'b0;
    last_data    = 8'h00;
`ifdef ESC_BYTE_CNT_EN
    last_cnt = 16'd0;
`endif
    test_reset();
    test_lpdt();
    test_ulps();
    test_trigger();
    test_bad_cmd();
    test_sync_error();
    test_back_to_back();
    test_reset_mid_lpdt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/esc_deserializer.md
Name: esc_deserializer

Overview:
Escape-mode receive deserializer, the receive-side counterpart of the escape-mode serializer. It collects serial bits MSB-first, one bit per RxClkEsc edge, while EscDesEn is high. The first byte of each escape sequence is decoded as an entry command: LPDT, ULPS or trigger-reset. In LPDT, the block presents each following payload byte on a parallel bus with a one-cycle valid strobe. It sits between the LP escape clock/bit recovery logic and the PPI RX escape interface.

Parameters:
LPDT_CMD, 8'hE1, entry command byte selecting low-power data transmission
ULPS_CMD, 8'h1E, entry command byte selecting ultra-low-power state
TRIG_CMD, 8'h62, entry command byte selecting trigger-reset

Ports:
RxClkEsc  input  1  escape-mode clock; one serial bit is sampled per rising edge
RstN  input  1  asynchronous reset, active-low
SerBit  input  1  serial data bit, MSB of each byte first
EscDesEn  input  1  high for the whole escape sequence; low means idle or exit
RxDataEsc  output  8  last completed LPDT payload byte
RxValidEsc  output  1  one-cycle strobe; RxDataEsc is new in this cycle
RxLpdtEsc  output  1  high while in LPDT mode
RxUlpsEsc  output  1  high while in ULPS
RxTriggerEsc  output  1  one-cycle pulse when TRIG_CMD is decoded
ErrEsc  output  1  one-cycle pulse when the command byte is not recognised
ErrSyncEsc  output  1  one-cycle pulse when EscDesEn falls mid-byte
RxByteCnt  output  16  LPDT payload byte count; present only with ESC_BYTE_CNT_EN

Behaviour:
- Reset (async, RstN low):
  - State IDLE; bit counter 0; shift register 0.
  - All outputs 0.
- Sampling:
  - On an edge with EscDesEn=1, SerBit shifts into shift[0] (shift <= {shift[6:0],SerBit}) and the 3-bit bit counter increments.
  - The counter wraps 7->0 on the edge that completes a byte.
  - The completed byte is {shift[6:0],SerBit}.
  - Edges with EscDesEn=0 never sample.
- States: IDLE, CMD, LPDT, ULPS, HOLD.
- IDLE:
  - EscDesEn=1 -> CMD, and the same edge samples bit 7 of the command byte.
- CMD, when the byte completes:
  - LPDT_CMD -> LPDT; RxLpdtEsc=1 from the next cycle.
  - ULPS_CMD -> ULPS; RxUlpsEsc=1 from the next cycle.
  - TRIG_CMD -> HOLD; RxTriggerEsc pulses for 1 cycle.
  - Any other value -> HOLD; ErrEsc pulses for 1 cycle.
  - The command byte never appears on RxDataEsc.
- LPDT:
  - Each completed byte loads RxDataEsc on that edge; RxValidEsc=1 for exactly the following cycle.
  - Latency: RxValidEsc rises at the edge that samples bit 0 of the byte.
  - Back-to-back bytes give one strobe every 8 cycles. RxDataEsc holds its value between strobes.
- ULPS / HOLD: bits are ignored (counter and shift frozen) until EscDesEn falls.
- Exit (EscDesEn=0 in any non-IDLE state):
  - Next state IDLE; RxLpdtEsc and RxUlpsEsc go 0 on that edge; bit counter and shift cleared.
  - If the state is CMD or LPDT and the bit counter is nonzero, ErrSyncEsc pulses for 1 cycle. A partial byte is discarded with no RxValidEsc.
  - RxDataEsc keeps its last value.
- Pulse outputs (RxValidEsc, RxTriggerEsc, ErrEsc, ErrSyncEsc) are registered and self-clearing after 1 cycle.
- Simultaneous events:
  - A byte completing on the last enabled edge, with EscDesEn=0 on the next edge: the byte is delivered normally and ErrSyncEsc stays 0.
  - RxValidEsc and the exit edge may coincide; both take effect.
- Re-entry: EscDesEn high again from IDLE starts a new command byte with counter 0.

Optional Feature:
ESC_BYTE_CNT_EN:
- Defined: 16-bit RxByteCnt port exists.
  - Cleared to 0 on reset and on IDLE->CMD.
  - Increments together with each RxValidEsc.
  - Saturates at 16'hFFFF.
  - Holds its value after exit until the next entry.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
- LPDT: EscDesEn=1, bytes E1, A5, 3C back-to-back -> RxLpdtEsc=1 after cycle 8; RxValidEsc at cycle 16 with A5 and cycle 24 with 3C; RxByteCnt=2 if enabled.
- ULPS: send 1E, hold EscDesEn=1 for 20 further cycles -> RxUlpsEsc=1 from cycle 8 until 1 cycle after EscDesEn falls; no RxValidEsc.
- Trigger and bad command:
  - Send 62 -> RxTriggerEsc 1-cycle pulse; later bits ignored.
  - Send 00 -> ErrEsc 1-cycle pulse; no mode output asserted.
- Sync error: E1 then 5 bits of a payload byte, then EscDesEn=0 -> ErrSyncEsc pulse; no RxValidEsc; RxLpdtEsc=0; RxDataEsc unchanged.
- Reset mid-LPDT: assert RstN=0 asynchronously after 3 payload bits -> all outputs 0 immediately. After release with EscDesEn=1, E1 then 7F -> RxDataEsc=7F with RxValidEsc.
